rr_grant_ctrl: RTL and testbench

//  Round-robin arbiter sharing one resource among 8 requesters. It replaces

---
 rtl/rr_grant_ctrl.sv | 128 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for 8 requesters with a bounded hold time.
// Drives a registered one-hot grant, its index, and an active-low 7-seg digit.
module rr_grant_ctrl #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_vld_o,
  output logic       timeout_o,
  output logic [6:0] seg_o
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

  localparam int CW        = (MAX_HOLD < 8) ? 3 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CW{1'b1}} : CW'(MAX_HOLD);

  logic          state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    gnt_q, gnt_d;
  logic          vld_q, vld_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] hold_q, hold_d;

  logic          found;
  logic [2:0]    winner;
  logic [2:0]    scanIdx;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    found   = 1'b0;
    winner  = 3'd0;
    scanIdx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scanIdx = ptr_q + 3'(i);
      if (!found && req_i[scanIdx]) begin
        found  = 1'b1;
        winner = scanIdx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    vld_d     = vld_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    case (state_q)
      STATE_IDLE: begin
        if (en_i && found) begin
          state_d = STATE_GRANT;
          idx_d   = winner;
          gnt_d   = 8'd1 << winner;
          vld_d   = 1'b1;
          hold_d  = '0;
        end
      end
      STATE_GRANT: begin
        // Release wins over pre-emption, so a dropped request never pulses timeout.
        if (!req_i[idx_q] || (MAX_HOLD != 0 && hold_q == CW'(HOLD_LAST))) begin
          state_d   = STATE_IDLE;
          ptr_d     = idx_q + 3'd1;
          idx_d     = 3'd0;
          gnt_d     = 8'd0;
          vld_d     = 1'b0;
          timeout_d = req_i[idx_q];
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STATE_IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      gnt_q     <= 8'd0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  // Decoded only from registered state so the display never glitches.
  always_comb begin
    seg_o = 7'b1111111;
    if (vld_q) begin
      case (idx_q)
        3'd0: seg_o = 7'b0000001;
        3'd1: seg_o = 7'b1001111;
        3'd2: seg_o = 7'b0010010;
        3'd3: seg_o = 7'b0000110;
        3'd4: seg_o = 7'b1001100;
        3'd5: seg_o = 7'b0100100;
        3'd6: seg_o = 7'b0100000;
        3'd7: seg_o = 7'b0001111;
        default: seg_o = 7'b1111111;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign gnt_vld_o = vld_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: one instance with MAX_HOLD=4, one with unlimited hold,
// both checked every cycle against an owner/held-cycles model.
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, enB;
  logic [7:0] req, reqB;
  logic [7:0] gnt, gntB;
  logic [2:0] idx, idxB;
  logic       vld, vldB, to, toB;
  logic [6:0] seg, segB;

  int compared = 0;
  int mismatched = 0;

  rr_grant_ctrl #(.MAX_HOLD(4)) dutA (
    .clk(clk), .rst_n(rst_n), .en_i(en), .req_i(req),
    .gnt_o(gnt), .gnt_idx_o(idx), .gnt_vld_o(vld), .timeout_o(to), .seg_o(seg)
  );

  rr_grant_ctrl #(.MAX_HOLD(0)) dutB (
    .clk(clk), .rst_n(rst_n), .en_i(enB), .req_i(reqB),
    .gnt_o(gntB), .gnt_idx_o(idxB), .gnt_vld_o(vldB), .timeout_o(toB), .seg_o(segB)
  );

  always #5 clk = ~clk;

  // Model: owner (-1 = none), cycles the grant has been visible, rotation pointer.
  int mOwner[2];
  int mHeld[2];
  int mPtr[2];
  int mTo[2];
  logic [6:0] segTable[8];

  initial begin
    segTable[0] = 7'b0000001; segTable[1] = 7'b1001111;
    segTable[2] = 7'b0010010; segTable[3] = 7'b0000110;
    segTable[4] = 7'b1001100; segTable[5] = 7'b0100100;
    segTable[6] = 7'b0100000; segTable[7] = 7'b0001111;
  end

  task automatic modelStep(input int u, input logic e, input logic [7:0] r, input int maxHold);
    mTo[u] = 0;
    if (mOwner[u] < 0) begin
      if (e && r != 8'd0) begin
        for (int k = 0; k < 8; k++) begin
          if (mOwner[u] < 0 && r[(mPtr[u] + k) % 8]) mOwner[u] = (mPtr[u] + k) % 8;
        end
        mHeld[u] = 1;
      end
    end else if (!r[mOwner[u]]) begin
      mPtr[u] = (mOwner[u] + 1) % 8;
      mOwner[u] = -1;
    end else if (maxHold != 0 && mHeld[u] == maxHold) begin
      mTo[u] = 1;
      mPtr[u] = (mOwner[u] + 1) % 8;
      mOwner[u] = -1;
    end else begin
      mHeld[u] = mHeld[u] + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mOwner[u] = -1; mHeld[u] = 0; mPtr[u] = 0; mTo[u] = 0;
      end
    end else begin
      modelStep(0, en, req, 4);
      modelStep(1, enB, reqB, 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic compareUnit(input int u, input logic [7:0] g, input logic [2:0] i,
                             input logic v, input logic t, input logic [6:0] s);
    logic [7:0] eg;
    logic [2:0] ei;
    logic [6:0] es;
    eg = (mOwner[u] >= 0) ? (8'd1 << mOwner[u]) : 8'd0;
    ei = (mOwner[u] >= 0) ? 3'(mOwner[u]) : 3'd0;
    es = (mOwner[u] >= 0) ? segTable[mOwner[u]] : 7'b1111111;
    checkOutput(u == 0 ? "A gnt" : "B gnt", 32'(g), 32'(eg));
    checkOutput(u == 0 ? "A gnt_idx" : "B gnt_idx", 32'(i), 32'(ei));
    checkOutput(u == 0 ? "A gnt_vld" : "B gnt_vld", 32'(v), 32'(mOwner[u] >= 0));
    checkOutput(u == 0 ? "A timeout" : "B timeout", 32'(t), 32'(mTo[u]));
    checkOutput(u == 0 ? "A seg" : "B seg", 32'(s), 32'(es));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      compareUnit(0, gnt, idx, vld, to, seg);
      compareUnit(1, gntB, idxB, vldB, toB, segB);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] r);
    en = e;
    req = r;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; req = 8'd0; enB = 1'b1; reqB = 8'd0;
    #1;
    checkOutput("reset gnt", 32'(gnt), 32'h00);
    checkOutput("reset seg", 32'(seg), 32'h7F);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Single request, release, then rotation past the pointer
    applyStimulus(1'b1, 8'h20);
    tick();
    checkOutput("grant 5 gnt", 32'(gnt), 32'h20);
    checkOutput("grant 5 idx", 32'(idx), 32'd5);
    checkOutput("grant 5 seg", 32'(seg), 32'(7'b0100100));
    applyStimulus(1'b1, 8'h00);
    tick();
    checkOutput("release 5 gnt", 32'(gnt), 32'h00);
    checkOutput("release 5 timeout", 32'(to), 32'd0);
    checkOutput("model ptr after 5", 32'(mPtr[0]), 32'd6);
    applyStimulus(1'b1, 8'h44);
    tick();
    checkOutput("ptr6 picks 6", 32'(gnt), 32'h40);
    applyStimulus(1'b1, 8'h04);
    tick();
    checkOutput("release 6 gnt", 32'(gnt), 32'h00);
    tick();
    checkOutput("wrap picks 2", 32'(gnt), 32'h04);
    applyStimulus(1'b1, 8'h00);
    tick();
    tick();

    // Enable gating of new grants only
    applyStimulus(1'b0, 8'h01);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("en=0 no grant", 32'(gnt), 32'h00);
    end
    applyStimulus(1'b1, 8'h01);
    tick();
    checkOutput("en=1 grant 0", 32'(gnt), 32'h01);
    applyStimulus(1'b0, 8'h01);
    tick();
    checkOutput("en=0 keeps owner", 32'(gnt), 32'h01);
    applyStimulus(1'b0, 8'h00);
    tick();
    checkOutput("release under en=0", 32'(gnt), 32'h00);

    // All requesting: 4-cycle holds, timeout at each hand-over
    doReset();
    applyStimulus(1'b1, 8'hFF);
    tick();
    checkOutput("ff first owner", 32'(gnt), 32'h01);
    tick(); tick(); tick();
    checkOutput("ff fourth cycle", 32'(gnt), 32'h01);
    tick();
    checkOutput("ff preempt gnt", 32'(gnt), 32'h00);
    checkOutput("ff preempt timeout", 32'(to), 32'd1);
    tick();
    checkOutput("ff second owner", 32'(gnt), 32'h02);
    checkOutput("ff timeout cleared", 32'(to), 32'd0);
    for (int c = 0; c < 40; c++) tick();
    applyStimulus(1'b1, 8'h00);
    tick();
    tick();

    // Release coinciding with the hold limit gives no timeout
    doReset();
    applyStimulus(1'b1, 8'h01);
    tick(); tick(); tick(); tick();
    checkOutput("limit cycle gnt", 32'(gnt), 32'h01);
    applyStimulus(1'b1, 8'h00);
    tick();
    checkOutput("limit release gnt", 32'(gnt), 32'h00);
    checkOutput("limit release timeout", 32'(to), 32'd0);

    // Reset mid-grant of owner 3
    doReset();
    applyStimulus(1'b1, 8'h08);
    tick();
    tick();
    checkOutput("owner 3 before reset", 32'(gnt), 32'h08);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset gnt", 32'(gnt), 32'h00);
    checkOutput("async reset vld", 32'(vld), 32'd0);
    checkOutput("async reset seg", 32'(seg), 32'h7F);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("owner 3 after reset", 32'(gnt), 32'h08);
    applyStimulus(1'b1, 8'h00);
    tick();

    // Unlimited hold on the second instance
    reqB = 8'h80;
    tick();
    checkOutput("B grant 7 seg", 32'(segB), 32'(7'b0001111));
    for (int c = 0; c < 100; c++) tick();
    checkOutput("B still 7", 32'(gntB), 32'h80);
    checkOutput("B no timeout", 32'(toB), 32'd0);
    reqB = 8'h00;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
